// File: rtl/adder_nbit_pkg.sv
// Shared constants for the registered N-bit ripple-carry adder.
package adder_nbit_pkg;

  localparam int unsigned ADDER_NBIT_DEFAULT_W = 8;

endpackage : adder_nbit_pkg

// File: rtl/full_adder.sv
// Single-bit full adder, one stage of the adder_nbit ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : full_adder

// File: rtl/adder_nbit.sv
// Registered N-bit unsigned ripple-carry adder: {carry_out, sum} = A + B + carry_in, 1-cycle latency.
// Optional macro ADDER_NBIT_OVF_EN adds a registered two's-complement overflow output ovf.
module adder_nbit
  import adder_nbit_pkg::*;
#(
  parameter int unsigned N = ADDER_NBIT_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         carry_in,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         carry_out,
  output logic [N-1:0] sum
`ifdef ADDER_NBIT_OVF_EN
  ,
  output logic         ovf
`endif
);

  logic [N:0]   w_c;
  logic [N-1:0] w_s;
  logic [N-1:0] r_sum;
  logic         r_carry;

  assign w_c[0] = carry_in;

  // Stage i consumes c[i] and produces c[i+1].
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_fa
    full_adder u_fa (
      .a    (A[gi]),
      .b    (B[gi]),
      .cin  (w_c[gi]),
      .sum  (w_s[gi]),
      .cout (w_c[gi+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_sum   <= w_s;
      r_carry <= w_c[N];
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry;

`ifdef ADDER_NBIT_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_c[N] ^ w_c[N-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule : adder_nbit

// File: tb/tb_adder_nbit.sv
// Self-checking bench for adder_nbit (N=8 and N=1 instances); honours ADDER_NBIT_OVF_EN.
module tb_adder_nbit;

  logic       clk;
  logic       rst;
  logic       ci8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       co8;
  logic [7:0] s8;
  logic       ci1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       co1;
  logic [0:0] s1;
`ifdef ADDER_NBIT_OVF_EN
  logic       ovf8;
  logic       ovf1;
`endif

  int n_checks;
  int n_fail;

  adder_nbit #(.N(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .carry_in  (ci8),
    .A         (a8),
    .B         (b8),
    .carry_out (co8),
    .sum       (s8)
`ifdef ADDER_NBIT_OVF_EN
    ,
    .ovf       (ovf8)
`endif
  );

  adder_nbit #(.N(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .carry_in  (ci1),
    .A         (a1),
    .B         (b1),
    .carry_out (co1),
    .sum       (s1)
`ifdef ADDER_NBIT_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    a8  = a;
    b8  = b;
    ci8 = ci;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    // Held in reset from time 0
    @(posedge clk); #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_initial got=%h exp=%h", got, 9'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    drive8(8'h31, 8'h2A, 1'b0);
    @(posedge clk); #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h05B) begin
      n_fail++;
      $display("FAIL reset_preadd got=%h exp=%h", got, 9'h05B);
    end
    // Mid-cycle async assert must clear outputs before any clock edge
    #2;
    rst = 1'b1;
    #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=%h", got, 9'h000);
    end
    @(posedge clk); #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=%h", got, 9'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h05B) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", got, 9'h05B);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [8:0] ve [4];
    logic [8:0] got;
    va = '{8'h00, 8'h03, 8'h31, 8'h07};
    vb = '{8'h0A, 8'h0A, 8'h2A, 8'h0B};
    ve = '{9'h00A, 9'h00D, 9'h05B, 9'h012};
    for (int i = 0; i < 4; i++) begin
      drive8(va[i], vb[i], 1'b0);
      // Previous result must still be held before the edge
      if (i > 0) begin
        #1;
        got = {co8, s8};
        n_checks++;
        if (got !== ve[i-1]) begin
          n_fail++;
          $display("FAIL basic_hold%0d got=%h exp=%h", i, got, ve[i-1]);
        end
      end
      @(posedge clk); #1;
      got = {co8, s8};
      n_checks++;
      if (got !== ve[i]) begin
        n_fail++;
        $display("FAIL basic%0d got=%h exp=%h", i, got, ve[i]);
      end
    end
  endtask

  task automatic test_carry();
    logic [8:0] got;
    drive8(8'h0F, 8'h00, 1'b1);
    @(posedge clk); #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h010) begin
      n_fail++;
      $display("FAIL carry_in got=%h exp=%h", got, 9'h010);
    end
    drive8(8'hFF, 8'h01, 1'b0);
    @(posedge clk); #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h100) begin
      n_fail++;
      $display("FAIL wrap got=%h exp=%h", got, 9'h100);
    end
    drive8(8'hFF, 8'hFF, 1'b1);
    @(posedge clk); #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h1FF) begin
      n_fail++;
      $display("FAIL all_ones got=%h exp=%h", got, 9'h1FF);
    end
    drive8(8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    got = {co8, s8};
    n_checks++;
    if (got !== 9'h000) begin
      n_fail++;
      $display("FAIL zero got=%h exp=%h", got, 9'h000);
    end
  endtask

`ifdef ADDER_NBIT_OVF_EN
  task automatic test_ovf();
    logic [9:0] got;
    drive8(8'h7F, 8'h01, 1'b0);
    @(posedge clk); #1;
    got = {ovf8, co8, s8};
    n_checks++;
    if (got !== 10'h280) begin
      n_fail++;
      $display("FAIL ovf_pos got=%h exp=%h", got, 10'h280);
    end
    drive8(8'h80, 8'h80, 1'b0);
    @(posedge clk); #1;
    got = {ovf8, co8, s8};
    n_checks++;
    if (got !== 10'h300) begin
      n_fail++;
      $display("FAIL ovf_neg got=%h exp=%h", got, 10'h300);
    end
    drive8(8'h05, 8'h03, 1'b0);
    @(posedge clk); #1;
    got = {ovf8, co8, s8};
    n_checks++;
    if (got !== 10'h008) begin
      n_fail++;
      $display("FAIL ovf_none got=%h exp=%h", got, 10'h008);
    end
  endtask
`endif

  task automatic test_random();
    int         sum8;
    int         sum1;
    int         ss8;
    int         ss1;
    logic [8:0] exp8;
    logic [1:0] exp1;
    logic       eo8;
    logic       eo1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      ci8 = 1'($urandom);
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      ci1 = 1'($urandom);
      sum8 = int'(a8) + int'(b8) + int'(ci8);
      sum1 = int'(a1) + int'(b1) + int'(ci1);
      exp8 = 9'(sum8);
      exp1 = 2'(sum1);
      ss8  = int'($signed(a8)) + int'($signed(b8)) + int'(ci8);
      ss1  = int'($signed(a1)) + int'($signed(b1)) + int'(ci1);
      eo8  = (ss8 > 127) || (ss8 < -128);
      eo1  = (ss1 > 0) || (ss1 < -1);
      @(posedge clk); #1;
      n_checks++;
      if ({co8, s8} !== exp8) begin
        n_fail++;
        $display("FAIL rand8 it=%0d got=%h exp=%h", i, {co8, s8}, exp8);
      end
      n_checks++;
      if ({co1, s1} !== exp1) begin
        n_fail++;
        $display("FAIL rand1 it=%0d got=%h exp=%h", i, {co1, s1}, exp1);
      end
`ifdef ADDER_NBIT_OVF_EN
      n_checks++;
      if ({ovf8, ovf1} !== {eo8, eo1}) begin
        n_fail++;
        $display("FAIL rand_ovf it=%0d got=%b exp=%b", i, {ovf8, ovf1}, {eo8, eo1});
      end
`else
      if (eo8 === 1'bx || eo1 === 1'bx) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_model it=%0d got=x exp=known", i);
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a8  = '0;
    b8  = '0;
    ci8 = 1'b0;
    a1  = '0;
    b1  = '0;
    ci1 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
`ifdef ADDER_NBIT_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adder_nbit
